// File: rtl/pc_ras.sv
// Fetch-stage program counter with a circular return-address stack.
// Priority per cycle: stall > branch > ret > call > sequential increment.
module pc_ras #(
  parameter  int ADDR_W       = 11,
  parameter  int INCR         = 1,
  parameter  int RESET_VECTOR = 0,
  parameter  int RAS_DEPTH    = 4,
  localparam int CNT_W        = $clog2(RAS_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_address,
  input  logic              call_valid,
  input  logic [ADDR_W-1:0] call_address,
  input  logic              ret_valid,
  output logic [ADDR_W-1:0] cnt,
  output logic [CNT_W-1:0]  ras_count,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  localparam int                PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] INCR_A   = ADDR_W'(INCR);
  localparam logic [ADDR_W-1:0] RST_A    = ADDR_W'(RESET_VECTOR);
  localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, seq_addr;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              push;

  // Top pointer wraps modulo RAS_DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_MAX : p - PTR_W'(1);
  endfunction

  always_comb begin
    seq_addr = cnt_q + INCR_A;
    cnt_d    = cnt_q;
    top_d    = top_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    push     = 1'b0;
    if (!stall) begin
      if (branch_valid) begin
        cnt_d = branch_address;
      end else if (ret_valid) begin
        if (count_q != '0) begin
          cnt_d   = ras_q[top_q];
          top_d   = ptr_dec(top_q);
          count_d = count_q - CNT_W'(1);
        end else begin
          cnt_d = seq_addr;
          unf_d = 1'b1;
        end
      end else if (call_valid) begin
        // When full, advancing the pointer lands on the oldest entry, so the
        // push naturally overwrites it.
        push  = 1'b1;
        cnt_d = call_address;
        top_d = ptr_inc(top_q);
        if (count_q < CNT_FULL) count_d = count_q + CNT_W'(1);
        else                    ovf_d   = 1'b1;
      end else begin
        cnt_d = seq_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= RST_A;
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push && !reset) ras_q[top_d] <= seq_addr;
  end

  assign cnt           = cnt_q;
  assign ras_count     = count_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_ras.sv
// Directed bench for pc_ras: default configuration plus a second instance
// with RESET_VECTOR=0x40, INCR=2.
module tb_pc_ras;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, branch_valid, call_valid, ret_valid;
  logic [10:0] branch_address, call_address;
  logic [10:0] cnt;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow;

  logic        reset2, stall2, branch_valid2, call_valid2, ret_valid2;
  logic [10:0] branch_address2, call_address2;
  logic [10:0] cnt2;
  logic [2:0]  ras_count2;
  logic        ras_overflow2, ras_underflow2;

  int total = 0;
  int bad   = 0;

  pc_ras #(.ADDR_W(11), .INCR(1), .RESET_VECTOR(0), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_valid(branch_valid), .branch_address(branch_address),
    .call_valid(call_valid), .call_address(call_address),
    .ret_valid(ret_valid), .cnt(cnt), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  pc_ras #(.ADDR_W(11), .INCR(2), .RESET_VECTOR(11'h40), .RAS_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset2), .stall(stall2),
    .branch_valid(branch_valid2), .branch_address(branch_address2),
    .call_valid(call_valid2), .call_address(call_address2),
    .ret_valid(ret_valid2), .cnt(cnt2), .ras_count(ras_count2),
    .ras_overflow(ras_overflow2), .ras_underflow(ras_underflow2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of dut with the given requests; requests drop afterwards.
  task automatic cyc(input logic rs, input logic st, input logic br, input logic [10:0] ba,
                     input logic ca, input logic [10:0] cad, input logic re);
    reset = rs; stall = st; branch_valid = br; branch_address = ba;
    call_valid = ca; call_address = cad; ret_valid = re;
    tick();
    reset = 1'b0; stall = 1'b0; branch_valid = 1'b0; call_valid = 1'b0; ret_valid = 1'b0;
  endtask

  task automatic cyc2(input logic rs, input logic ca, input logic [10:0] cad, input logic re);
    reset2 = rs; call_valid2 = ca; call_address2 = cad; ret_valid2 = re;
    tick();
    reset2 = 1'b0; call_valid2 = 1'b0; ret_valid2 = 1'b0;
  endtask

  task automatic chk1(input string tag, input logic [10:0] c, input logic [2:0] n,
                      input logic ov, input logic un);
    chk({tag, ".cnt"},   {21'b0, cnt},           {21'b0, c});
    chk({tag, ".count"}, {29'b0, ras_count},     {29'b0, n});
    chk({tag, ".ovf"},   {31'b0, ras_overflow},  {31'b0, ov});
    chk({tag, ".unf"},   {31'b0, ras_underflow}, {31'b0, un});
  endtask

  task automatic chk2(input string tag, input logic [10:0] c, input logic [2:0] n,
                      input logic ov, input logic un);
    chk({tag, ".cnt"},   {21'b0, cnt2},           {21'b0, c});
    chk({tag, ".count"}, {29'b0, ras_count2},     {29'b0, n});
    chk({tag, ".ovf"},   {31'b0, ras_overflow2},  {31'b0, ov});
    chk({tag, ".unf"},   {31'b0, ras_underflow2}, {31'b0, un});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_valid = 1'b0; call_valid = 1'b0; ret_valid = 1'b0;
    branch_address = '0; call_address = '0;
    reset2 = 1'b0; stall2 = 1'b0; branch_valid2 = 1'b0; call_valid2 = 1'b0; ret_valid2 = 1'b0;
    branch_address2 = '0; call_address2 = '0;

    // Reset for 2 cycles, then 5 idle cycles.
    cyc(1, 0, 0, 0, 0, 0, 0); chk1("rst0", 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0); chk1("rst1", 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("seq.cnt", {21'b0, cnt}, i);
    end
    chk("seq.count", {29'b0, ras_count}, 0);

    // Advance to 10, branch to all-ones, wrap.
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("at10", {21'b0, cnt}, 10);
    cyc(0, 0, 1, 11'h7FF, 0, 0, 0); chk1("br7ff", 11'h7FF, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);       chk("wrap0", {21'b0, cnt}, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);       chk("wrap1", {21'b0, cnt}, 1);

    // Nested call/return.
    cyc(0, 0, 1, 11'd5, 0, 0, 0);      chk("at5", {21'b0, cnt}, 5);
    cyc(0, 0, 0, 0, 1, 11'h100, 0);    chk1("call1", 11'h100, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);          chk("at101", {21'b0, cnt}, 11'h101);
    cyc(0, 0, 0, 0, 1, 11'h200, 0);    chk1("call2", 11'h200, 2, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);          chk1("ret1", 11'h102, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);          chk1("ret2", 11'd6, 0, 0, 0);

    // Five calls from cnt=1..5 overflow a depth-4 stack.
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 0, 1, 11'(k), 0, 0, 0);
      cyc(0, 0, 0, 0, 1, (k % 2) ? 11'h300 : 11'h400, 0);
      chk("ovcall.cnt", {21'b0, cnt}, (k % 2) ? 32'h300 : 32'h400);
      chk("ovcall.count", {29'b0, ras_count}, (k < 4) ? k : 4);
      chk("ovcall.ovf", {31'b0, ras_overflow}, (k == 5) ? 1 : 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 1); chk1("ovret1", 11'd6, 3, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1); chk1("ovret2", 11'd5, 2, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1); chk1("ovret3", 11'd4, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1); chk1("ovret4", 11'd3, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1); chk1("ovret5", 11'd4, 0, 1, 1);

    // Stall beats branch and call; call+ret together only pops.
    cyc(0, 0, 0, 0, 1, 11'd19, 0);      chk1("pre.call", 11'd19, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);           chk("at20", {21'b0, cnt}, 20);
    cyc(0, 1, 1, 11'h55, 1, 11'h66, 0); chk1("stall1", 11'd20, 1, 1, 1);
    cyc(0, 1, 1, 11'h55, 1, 11'h66, 1); chk1("stall2", 11'd20, 1, 1, 1);
    cyc(0, 0, 0, 0, 1, 11'h66, 1);      chk1("callret", 11'd5, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);           chk("after.cr", {21'b0, cnt}, 6);

    // Reset in the middle of a 3-deep chain with requests pending.
    cyc(0, 0, 0, 0, 1, 11'h10, 0);
    cyc(0, 0, 0, 0, 1, 11'h20, 0);
    cyc(0, 0, 0, 0, 1, 11'h30, 0);    chk1("chain3", 11'h30, 3, 1, 1);
    cyc(1, 0, 0, 0, 1, 11'h44, 1);    chk1("midrst", 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);         chk1("rst.ret", 11'd1, 0, 0, 1);

    // Return address computed modulo 2^ADDR_W.
    cyc(0, 0, 1, 11'h7FF, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 11'h50, 0);    chk1("wcall", 11'h50, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);         chk1("wret", 11'h000, 0, 0, 1);

    // Second instance: RESET_VECTOR=0x40, INCR=2.
    cyc2(1, 0, 0, 0);
    cyc2(1, 0, 0, 0);                 chk2("d2.rst", 11'h40, 0, 0, 0);
    cyc2(0, 0, 0, 0);                 chk2("d2.seq", 11'h42, 0, 0, 0);
    cyc2(0, 1, 11'h100, 0);           chk2("d2.c1", 11'h100, 1, 0, 0);
    cyc2(0, 1, 11'h200, 0);           chk2("d2.c2", 11'h200, 2, 0, 0);
    cyc2(0, 1, 11'h300, 0);           chk2("d2.c3", 11'h300, 3, 0, 0);
    cyc2(0, 0, 0, 1);                 chk2("d2.r1", 11'h202, 2, 0, 0);
    cyc2(0, 1, 11'h300, 0);           chk2("d2.c3b", 11'h300, 3, 0, 0);
    cyc2(1, 1, 11'h77, 1);            chk2("d2.midrst", 11'h40, 0, 0, 0);
    cyc2(0, 0, 0, 1);                 chk2("d2.unf", 11'h42, 0, 0, 1);
    cyc2(0, 1, 11'h10, 0);            chk2("d2.c4", 11'h10, 1, 0, 1);
    cyc2(0, 0, 0, 1);                 chk2("d2.r4", 11'h44, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
